serial_full_subtractor: RTL and testbench

SERIAL_FULL_SUBTRACTOR -- requirements
Module: serial_full_subtractor

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_sub.sv | 13 +
 rtl/serial_full_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_full_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_arith_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when a < b + bin.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial full subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per
// clock, LSB first, with a valid/ready handshake on both sides.
// Optional self-checks: define SERIAL_FULL_SUBTRACTOR_ASSERT_EN to compile
// immediate assertions on each processed bit and on the final result.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   SHIFT | processing one bit per cycle, counter 0..WIDTH-1
//   DONE  | out_valid high, result held until out_ready
module serial_full_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] diff_d;

    full_sub u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_d)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands aligned.
    assign diff_d = {d_bit, diff_q[WIDTH-1:1]};

    // Handshake FSM and serial datapath; outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            br_q        <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        br_q       <= bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    br_q   <= br_d;
                    diff_q <= diff_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        bout_q      <= br_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef SERIAL_FULL_SUBTRACTOR_ASSERT_EN
    logic [WIDTH-1:0] a_lat_q;
    logic [WIDTH-1:0] b_lat_q;
    logic             bin_lat_q;
    logic [WIDTH:0]   ref_res;

    // Keep an untouched copy of the accepted operands for the end-of-run check.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat_q   <= '0;
            b_lat_q   <= '0;
            bin_lat_q <= 1'b0;
        end else if (state_q == IDLE && in_valid && in_ready_q) begin
            a_lat_q   <= a;
            b_lat_q   <= b;
            bin_lat_q <= bin;
        end
    end

    assign ref_res = {1'b1, a_lat_q} - {1'b0, b_lat_q} - {{WIDTH{1'b0}}, bin_lat_q};

    // Check every processed bit and the held result against plain arithmetic.
    always @(posedge clk) begin
        if (!rst) begin
            if (state_q == SHIFT) begin
                assert (d_bit == (a_q[0] ^ b_q[0] ^ br_q))
                else $error("serial_full_subtractor: bad d a=%h b=%h bin=%b cnt=%0d",
                            a_lat_q, b_lat_q, bin_lat_q, cnt_q);
                assert (br_d == ((~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q)))
                else $error("serial_full_subtractor: bad borrow a=%h b=%h bin=%b cnt=%0d",
                            a_lat_q, b_lat_q, bin_lat_q, cnt_q);
            end
            if (state_q == DONE) begin
                assert ({~bout_q, diff_q} == ref_res)
                else $error("serial_full_subtractor: bad result a=%h b=%h bin=%b diff=%h bout=%b",
                            a_lat_q, b_lat_q, bin_lat_q, diff_q, bout_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
module tb_serial_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, bin4, bout4;
    logic [3:0] a4, b4, diff4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    serial_full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8)
    );

    serial_full_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction reduced to w bits.
    function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, output logic [7:0] d, output logic bo);
        int r;
        r  = int'(a) - int'(b) - int'(bin);
        d  = 8'(r & ((1 << w) - 1));
        bo = (int'(a) < (int'(b) + int'(bin)));
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 8) ? out_valid8 : out_valid4;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 8) ? in_ready8 : in_ready4;
    endfunction

    function automatic logic [7:0] get_diff(input int w);
        return (w == 8) ? diff8 : {4'b0, diff4};
    endfunction

    function automatic logic get_bout(input int w);
        return (w == 8) ? bout8 : bout4;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic bin);
        if (w == 8) begin
            in_valid8 = v; a8 = a; b8 = b; bin8 = bin;
        end else begin
            in_valid4 = v; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin;
        end
    endtask

    task automatic set_rdy(input int w, input logic r);
        if (w == 8) out_ready8 = r;
        else        out_ready4 = r;
    endtask

    // One full transaction: accept, wait for result, optionally stall, release.
    // lat counts clock edges from the accepting edge (inclusive) to out_valid.
    task automatic xact(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int stall, input bit rand_rdy,
                        output logic [7:0] d, output logic bo);
        int   lat;
        logic stable;
        d  = '0;
        bo = 1'b0;
        chk("in_ready_idle", 32'(get_ir(w)), 32'd1);
        set_in(w, 1'b1, a, b, bin);
        tick();
        set_in(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 1;
        while (!get_ov(w) && lat < 100) begin
            set_in(w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            if (rand_rdy) set_rdy(w, 1'($urandom));
            tick();
            lat++;
        end
        set_rdy(w, 1'b0);
        set_in(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        if (!get_ov(w)) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(lat), 32'(w + 1));
        d  = get_diff(w);
        bo = get_bout(w);
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            set_in(w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            if (get_ov(w) !== 1'b1 || get_diff(w) !== d || get_bout(w) !== bo || get_ir(w) !== 1'b0)
                stable = 1'b0;
        end
        if (stall > 0) chk("hold_stable", 32'(stable), 32'd1);
        set_in(w, 1'b0, 8'h00, 8'h00, 1'b0);
        set_rdy(w, 1'b1);
        tick();
        set_rdy(w, 1'b0);
        chk("release_out_valid", 32'(get_ov(w)), 32'd0);
        chk("release_in_ready", 32'(get_ir(w)), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, ed;
        logic       bo, ebo;
        logic [8:0] ib;
        logic [7:0] ra, rb;
        logic       rbin;

        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'h00, bin: 1'b1, d: 8'hFE, bo: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, bo: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h7F, bin: 1'b0, d: 8'h00, bo: 1'b0};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, d: 8'h4B, bo: 1'b0};

        rst = 1'b1;
        set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(4, 1'b0, 8'h00, 8'h00, 1'b0);
        out_ready8 = 1'b0;
        out_ready4 = 1'b0;
        tick();
        tick();
        chk("reset_in_ready", 32'(in_ready8), 32'd1);
        chk("reset_out_valid", 32'(out_valid8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            xact(8, vecs[i].a, vecs[i].b, vecs[i].bin, i % 3, 1'b0, d, bo);
            chk("vec_diff", 32'(d), 32'(vecs[i].d));
            chk("vec_bout", 32'(bo), 32'(vecs[i].bo));
        end

        // Long stall in DONE: result and handshake state must hold.
        xact(8, 8'h3C, 8'h0F, 1'b1, 20, 1'b0, d, bo);
        chk("stall_diff", 32'(d), 32'h2C);
        chk("stall_bout", 32'(bo), 32'd0);

        // Reset mid-shift at bit 4 abandons the transaction.
        set_in(8, 1'b1, 8'h55, 8'h22, 1'b0);
        tick();
        set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready8), 32'd1);
        chk("midrst_out_valid", 32'(out_valid8), 32'd0);
        chk("midrst_diff", 32'(diff8), 32'd0);
        chk("midrst_bout", 32'(bout8), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid8) seen = 1'b1;
            end
            chk("midrst_no_pulse", 32'(seen), 32'd0);
        end
        xact(8, 8'h10, 8'h01, 1'b0, 0, 1'b0, d, bo);
        chk("post_rst_diff", 32'(d), 32'h0F);
        chk("post_rst_bout", 32'(bo), 32'd0);

        // Random 8-bit operands against the arithmetic model.
        for (int i = 0; i < 120; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            model(8, ra, rb, rbin, ed, ebo);
            xact(8, ra, rb, rbin, int'($urandom_range(0, 3)), 1'b1, d, bo);
            chk("rand8_diff", 32'(d), 32'(ed));
            chk("rand8_bout", 32'(bo), 32'(ebo));
        end

        // Exhaustive 4-bit sweep with random backpressure.
        for (int i = 0; i < 512; i++) begin
            ib = 9'(i);
            model(4, {4'b0, ib[3:0]}, {4'b0, ib[7:4]}, ib[8], ed, ebo);
            xact(4, {4'b0, ib[3:0]}, {4'b0, ib[7:4]}, ib[8],
                 int'($urandom_range(0, 2)), 1'b1, d, bo);
            chk("sweep4_diff", 32'(d), 32'(ed));
            chk("sweep4_bout", 32'(bo), 32'(ebo));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
